// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: byte FIFO feeding an 11-bit frame serializer on ps2_clk/ps2_data.
// Define PS2_TX_PERR_INJ_EN to add the perr_inj input, which flips the parity bit of a frame.
//
// state    | meaning
// ST_IDLE  | lines high, pop next byte when queue not empty
// ST_HI    | ps2_clk high, current bit on ps2_data
// ST_LO    | ps2_clk low, receiver samples on the falling edge
// ST_GAP   | lines high, inter-frame spacing
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 16,
  parameter int GAP_CYC    = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
`ifdef PS2_TX_PERR_INJ_EN
  input  logic       perr_inj,
`endif
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYC - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [9:0]      frame_q, frame_d;
  logic            ps2_clk_q, ps2_clk_d;
  logic            ps2_data_q, ps2_data_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      head;
  logic            push, pop, perr_bit;

`ifdef PS2_TX_PERR_INJ_EN
  assign perr_bit = perr_inj;
`else
  assign perr_bit = 1'b0;
`endif

  // Push-when-full always drops, even if a pop happens the same clock.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = (state_q == ST_IDLE) && !empty_q;
    head       = mem_q[rd_ptr_q];
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // frame_q holds the bits still to send after the one on ps2_data: b1..b10, LSB next.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    frame_d    = frame_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          frame_d    = {1'b1, (~^head) ^ perr_bit, head};
          bit_idx_d  = 4'd0;
          timer_d    = HALF_LOAD;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
          state_d    = ST_HI;
        end
      end
      ST_HI: begin
        if (timer_q == '0) begin
          ps2_clk_d = 1'b0;
          timer_d   = HALF_LOAD;
          state_d   = ST_LO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LO: begin
        if (timer_q == '0) begin
          ps2_clk_d = 1'b1;
          if (bit_idx_q < 4'd10) begin
            bit_idx_d  = bit_idx_q + 4'd1;
            ps2_data_d = frame_q[0];
            frame_d    = {1'b1, frame_q[9:1]};
            timer_d    = HALF_LOAD;
            state_d    = ST_HI;
          end else begin
            ps2_data_d = 1'b1;
            timer_d    = GAP_LOAD;
            state_d    = ST_GAP;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else timer_d = timer_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: vector table, corner sequences and random bytes vs a frame model.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYC    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_BUSY = 22 * CLK_DIV + GAP_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       perr_inj = 1'b0;
  logic       full, empty, busy, overflow, ps2_clk, ps2_data;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
`ifdef PS2_TX_PERR_INJ_EN
    .perr_inj(perr_inj),
`endif
    .full(full), .empty(empty), .busy(busy), .overflow(overflow),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Line monitor: acts like a receiver sampling data on every ps2_clk fall.
  logic [10:0] rx_q[$];
  int          busy_q[$];
  logic        prev_clk = 1'b1, prev_data = 1'b1;
  logic [10:0] sh = '0;
  int          bit_cnt = 0, fall_cnt = 0, glitch_cnt = 0;
  int          busy_run = 0, idle_run = 0, last_gap = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      bit_cnt = 0; busy_run = 0; idle_run = 0;
      prev_clk = 1'b1; prev_data = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        sh = {ps2_data, sh[10:1]};
        bit_cnt++;
        fall_cnt++;
        if (bit_cnt == 11) begin
          rx_q.push_back(sh);
          bit_cnt = 0;
        end
      end
      if (!prev_clk && !ps2_clk && (ps2_data != prev_data)) glitch_cnt++;
      if (busy) begin
        if (busy_run == 0) last_gap = idle_run;
        busy_run++;
        idle_run = 0;
      end else begin
        if (busy_run != 0) busy_q.push_back(busy_run);
        busy_run = 0;
        idle_run++;
      end
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b0; perr_inj = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rx_q.delete();
    busy_q.delete();
  endtask

  task automatic push1(input logic [7:0] b);
    @(negedge clk);
    wr_data = b; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check("frame_count", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check("idle_timeout", {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] seq3[4];
  logic [7:0] exp4[5];
  logic [7:0] rnd_bytes[$];
  int f0, k;

  initial begin
    vecs[0] = '{8'h1C, 11'h438};
    vecs[1] = '{8'hF0, 11'h7E0};
    vecs[2] = '{8'h1B, 11'h636};
    vecs[3] = '{8'h00, 11'h600};
    vecs[4] = '{8'hFF, 11'h7FE};
    vecs[5] = '{8'h01, 11'h402};
    seq3 = '{8'h1C, 8'hF0, 8'h1C, 8'h1B};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ps2_clk", {31'd0, ps2_clk}, 1);
    check("rst_ps2_data", {31'd0, ps2_data}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_full", {31'd0, full}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_overflow", {31'd0, overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single frames from the vector table
    for (int i = 0; i < 6; i++) begin
      rx_q.delete(); busy_q.delete();
      f0 = fall_cnt;
      push1(vecs[i].data);
      wait_frames(1, 400);
      wait_idle(400);
      check("vec_frame", {21'd0, rx_q.size() > 0 ? rx_q[0] : 11'h0}, {21'd0, vecs[i].frame});
      check("vec_falls", fall_cnt - f0, 11);
      check("vec_busy_len", busy_q.size() > 0 ? busy_q[0] : 0, FRAME_BUSY);
    end
    check("vec_empty", {31'd0, empty}, 1);

    // four back-to-back pushes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_data = seq3[i]; wr_en = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("b2b_not_empty", {31'd0, empty}, 0);
    wait_frames(4, 4 * (FRAME_BUSY + 2) + 50);
    wait_idle(400);
    for (int i = 0; i < 4; i++)
      check("b2b_order", {21'd0, rx_q.size() > i ? rx_q[i] : 11'h0}, {21'd0, model_frame(seq3[i])});
    check("b2b_overflow", {31'd0, overflow}, 0);
    check("b2b_idle_gap", last_gap, 1);

    // fill while busy, then push on the pop clock while full
    do_reset();
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push1(exp4[0]);
    repeat (3) @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      wr_data = exp4[i]; wr_en = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("fill_full", {31'd0, full}, 1);
    check("fill_no_ovf", {31'd0, overflow}, 0);
    k = 0;
    while (busy && k < 300) begin @(negedge clk); k++; end
    check("fill_wait_idle", {31'd0, busy}, 0);
    wr_data = 8'h99; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("drop_ovf", {31'd0, overflow}, 1);
    check("drop_full_after_pop", {31'd0, full}, 0);
    wait_frames(5, 5 * (FRAME_BUSY + 2) + 50);
    wait_idle(400);
    repeat (300) @(negedge clk);
    check("drop_frame_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check("drop_order", {21'd0, rx_q.size() > i ? rx_q[i] : 11'h0}, {21'd0, model_frame(exp4[i])});
    check("ovf_sticky", {31'd0, overflow}, 1);
    check("drop_empty", {31'd0, empty}, 1);

    // reset during bit 5 low phase
    do_reset();
    f0 = fall_cnt;
    push1(8'h1C);
    k = 0;
    while (fall_cnt - f0 < 6 && k < 200) begin @(negedge clk); k++; end
    check("abort_reach_bit5", fall_cnt - f0, 6);
    check("abort_clk_low", {31'd0, ps2_clk}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ps2_clk", {31'd0, ps2_clk}, 1);
    check("abort_ps2_data", {31'd0, ps2_data}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_empty", {31'd0, empty}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = fall_cnt;
    repeat (200) @(negedge clk);
    check("abort_no_falls", fall_cnt - f0, 0);
    check("abort_no_frame", rx_q.size(), 0);

`ifdef PS2_TX_PERR_INJ_EN
    do_reset();
    perr_inj = 1'b1;
    push1(8'h1B);
    repeat (3) @(negedge clk);
    perr_inj = 1'b0;
    push1(8'h1B);
    wait_frames(2, 2 * (FRAME_BUSY + 2) + 50);
    check("perr_frame", {21'd0, rx_q.size() > 0 ? rx_q[0] : 11'h0}, {21'd0, 11'h436});
    check("perr_clean", {21'd0, rx_q.size() > 1 ? rx_q[1] : 11'h0}, {21'd0, 11'h636});
    wait_idle(400);
`endif

    // random bytes with random spacing vs the frame model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(20, 150)) @(negedge clk);
      k = 0;
      while (full && k < 500) begin @(negedge clk); k++; end
      rnd_bytes.push_back(8'($urandom_range(0, 255)));
      push1(rnd_bytes[i]);
    end
    wait_frames(16, 16 * (FRAME_BUSY + 2) + 500);
    wait_idle(400);
    for (int i = 0; i < 16; i++)
      check("rnd_frame", {21'd0, rx_q.size() > i ? rx_q[i] : 11'h0}, {21'd0, model_frame(rnd_bytes[i])});
    for (int i = 0; i < busy_q.size(); i++)
      check("rnd_busy_len", busy_q[i], FRAME_BUSY);
    check("rnd_overflow", {31'd0, overflow}, 0);
    check("data_stable_while_low", glitch_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
